// File: rtl/param_seq_alu.sv
// rtl/param_seq_alu.sv - sequential ALU: single-cycle ops plus a shift-add multiplier that takes WIDTH cycles
module param_seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           S,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 C,
  output logic                 V,
  output logic                 Z,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;

  logic [WIDTH:0]       ext;
  logic [WIDTH-1:0]     op_res;
  logic                 op_c;
  logic                 op_v;
  logic [SW-1:0]        sh;

  // ext carries one extra bit so carry, borrow and the last shifted-out bit share one path
  always_comb begin
    ext    = '0;
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    sh     = B[SW-1:0];
    case (S)
      3'b000: begin
        ext    = {1'b0, A} + (WIDTH+1)'(1);
        op_res = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
        op_v   = ~A[MSB] & op_res[MSB];
      end
      3'b001: begin
        ext    = {1'b0, A} + {1'b0, B};
        op_res = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
        op_v   = (A[MSB] == B[MSB]) && (op_res[MSB] != A[MSB]);
      end
      3'b010: begin
        ext    = {1'b0, A} - {1'b0, B};
        op_res = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
        op_v   = (A[MSB] != B[MSB]) && (op_res[MSB] != A[MSB]);
      end
      3'b011: op_res = A & B;
      3'b100: op_res = A | B;
      3'b101: op_res = A ^ B;
      3'b110: begin
        ext    = {1'b0, A} << sh;
        op_res = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
      end
      default: ;
    endcase
  end

  assign prod_next = mplier[0] ? (prod + mcand) : prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      Y      <= '0;
      C      <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (S == 3'b111) begin
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              prod   <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else begin
              Y    <= {{WIDTH{1'b0}}, op_res};
              C    <= op_c;
              V    <= op_v;
              Z    <= (op_res == '0);
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            Y     <= prod_next;
            C     <= |prod_next[2*WIDTH-1:WIDTH];
            V     <= 1'b0;
            Z     <= (prod_next == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_alu.sv
// tb/tb_param_seq_alu.sv - randomized self-checking bench for param_seq_alu with a behavioural model
module tb_param_seq_alu;

  localparam int W    = 4;
  localparam int M    = 1 << W;
  localparam int HALF = M / 2;
  localparam int SHM  = (1 << $clog2(W)) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       S = '0;
  logic [W-1:0]     A = '0;
  logic [W-1:0]     B = '0;
  logic [2*W-1:0]   Y;
  logic             C, V, Z, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_y = 0, m_c = 0, m_v = 0, m_z = 0, m_busy = 0, m_done = 0;
  int m_left = 0, pend_y = 0, pend_c = 0;

  param_seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .S(S), .A(A), .B(B),
    .Y(Y), .C(C), .V(V), .Z(Z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= HALF) ? x - M : x;
  endfunction

  // Arithmetic reference: plain integer maths on the operand values
  function automatic void ref_op(input int s, input int a, input int b,
                                 output int y, output int c, output int v);
    int r, sr, sh;
    y = 0; c = 0; v = 0;
    case (s)
      0: begin r = a + 1; y = r % M; c = int'(r >= M); sr = sx(a) + 1;
               v = int'(sr >= HALF || sr < -HALF); end
      1: begin r = a + b; y = r % M; c = int'(r >= M); sr = sx(a) + sx(b);
               v = int'(sr >= HALF || sr < -HALF); end
      2: begin y = (a - b + M) % M; c = int'(a < b); sr = sx(a) - sx(b);
               v = int'(sr >= HALF || sr < -HALF); end
      3: y = a & b;
      4: y = a | b;
      5: y = a ^ b;
      6: begin sh = b & SHM; y = (a << sh) % M;
               c = (sh == 0) ? 0 : ((a >> (W - sh)) & 1); end
      default: begin y = a * b; c = int'(y >= M); end
    endcase
  endfunction

  task automatic model_step(input int r, input int st, input int s, input int a, input int b);
    int y, c, v;
    m_done = 0;
    if (r != 0) begin
      m_y = 0; m_c = 0; m_v = 0; m_z = 0; m_busy = 0; m_left = 0;
    end else if (m_busy != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_y = pend_y; m_c = pend_c; m_v = 0; m_z = int'(pend_y == 0);
        m_done = 1; m_busy = 0;
      end
    end else if (st != 0) begin
      ref_op(s, a, b, y, c, v);
      if (s == 7) begin
        pend_y = y; pend_c = c; m_busy = 1; m_left = W;
      end else begin
        m_y = y; m_c = c; m_v = v; m_z = int'(y == 0); m_done = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("Y", int'(Y), m_y);
    chk("C", int'(C), m_c);
    chk("V", int'(V), m_v);
    chk("Z", int'(Z), m_z);
    chk("busy", int'(busy), m_busy);
    chk("done", int'(done), m_done);
  endtask

  task automatic cycle(input int r, input int st, input int s, input int a, input int b);
    rst = r[0]; start = st[0]; S = s[2:0]; A = a[W-1:0]; B = b[W-1:0];
    @(posedge clk);
    model_step(r, st, s, a, b);
    #1;
    cyc++;
    compare_all();
  endtask

  initial begin
    int y, c, v;

    ref_op(0, 15, 0, y, c, v);
    chk("pin_inc_y", y, 0); chk("pin_inc_c", c, 1); chk("pin_inc_v", v, 0);
    ref_op(2, 4, 5, y, c, v);
    chk("pin_sub_y", y, 15); chk("pin_sub_c", c, 1);
    ref_op(1, 7, 1, y, c, v);
    chk("pin_add_v", v, 1);
    ref_op(6, 9, 1, y, c, v);
    chk("pin_shl_y", y, 2); chk("pin_shl_c", c, 1);
    ref_op(7, 15, 15, y, c, v);
    chk("pin_mul_y", y, 225); chk("pin_mul_c", c, 1);

    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 7, 3, 3);
    chk("rst_y", int'(Y), 0); chk("rst_busy", int'(busy), 0); chk("rst_done", int'(done), 0);

    cycle(0, 1, 0, 15, 0);
    chk("inc_y", int'(Y), 0); chk("inc_c", int'(C), 1); chk("inc_z", int'(Z), 1);
    chk("inc_v", int'(V), 0); chk("inc_done", int'(done), 1);
    cycle(0, 0, 0, 0, 0);
    chk("idle_done", int'(done), 0); chk("idle_hold_c", int'(C), 1);

    cycle(0, 1, 2, 3, 3);
    chk("sub0_y", int'(Y), 0); chk("sub0_z", int'(Z), 1); chk("sub0_c", int'(C), 0);
    chk("sub0_done", int'(done), 1);
    cycle(0, 1, 2, 4, 5);
    chk("sub1_y", int'(Y), 8'h0F); chk("sub1_c", int'(C), 1); chk("sub1_z", int'(Z), 0);
    chk("sub1_done", int'(done), 1);

    cycle(0, 1, 1, 7, 1);
    chk("add_y", int'(Y), 8'h08); chk("add_v", int'(V), 1); chk("add_c", int'(C), 0);
    cycle(0, 1, 6, 9, 1);
    chk("shl_y", int'(Y), 8'h02); chk("shl_c", int'(C), 1);

    cycle(0, 1, 7, 15, 15);
    chk("mul_busy0", int'(busy), 1);
    cycle(0, 1, 0, 3, 3);
    chk("mul_ignore_done", int'(done), 0); chk("mul_busy1", int'(busy), 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("mul_busy3", int'(busy), 1); chk("mul_done_early", int'(done), 0);
    cycle(0, 0, 0, 0, 0);
    chk("mul_y", int'(Y), 8'hE1); chk("mul_c", int'(C), 1); chk("mul_z", int'(Z), 0);
    chk("mul_done", int'(done), 1); chk("mul_busy_end", int'(busy), 0);
    cycle(0, 0, 0, 0, 0);
    chk("mul_no_extra_done", int'(done), 0);

    cycle(0, 1, 7, 5, 3);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("abort_y", int'(Y), 0); chk("abort_busy", int'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("abort_no_done", int'(done), 0);
    end
    cycle(0, 1, 3, 12, 10);
    chk("and_y", int'(Y), 8'h08); chk("and_done", int'(done), 1);

    for (int i = 0; i < 3000; i++) begin
      int r, st, s;
      r  = int'($urandom_range(0, 99) < 2);
      st = int'($urandom_range(0, 99) < 55);
      s  = int'($urandom_range(0, 7));
      cycle(r, st, s, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
